// File: rtl/bus030_pkg.sv
// Shared encodings for the 68030-style bus master: FSM states, SIZ codes, burst length,
// and the rule deciding whether a request may ask for a cache-line burst.
package bus030_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_BURST = 3'd3;
    localparam state_t ST_TERM  = 3'd4;
    localparam state_t ST_ERR   = 3'd5;

    typedef enum logic [1:0] {
        SIZ_LONG = 2'b00,
        SIZ_BYTE = 2'b01,
        SIZ_WORD = 2'b10,
        SIZ_LINE = 2'b11
    } siz_e;

    localparam int unsigned BURST_BEATS = 4;

    // Only long-aligned long reads may request a line burst.
    function automatic logic burst_ok(input logic burst, input logic rwn,
                                      input logic [1:0] siz, input logic [29:0] addr);
        return burst && rwn && (siz == SIZ_LONG) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Acknowledge watchdog: counts cycles since the last clear while run is high and
// flags the cycle in which TIMEOUT_CYC cycles without acknowledge have elapsed.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/bus_master_030.sv
// Request-to-bus master for a 68030-style bus with optional 4-beat line burst.
// Define BUS_TIMEOUT_EN to add the acknowledge watchdog and the ERR response path.
module bus_master_030 import bus030_pkg::*; #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        sysClk,
    input  logic        sysRESET,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [29:0] reqAddr,
    input  logic [1:0]  reqSIZ,
    input  logic        reqRWn,
    input  logic        reqBurst,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    output logic        rspLast,
    output logic        rspErr,
    output logic [31:0] rspRData,
    output logic [29:0] cpuAddr,
    output logic [1:0]  cpuSIZ,
    output logic        cpuRWn,
    output logic        cpuASn,
    output logic        cpuCBREQn,
    output logic [31:0] busDataOut,
    output logic        busDataOE,
    input  logic        ramACKn,
    input  logic        cpuCBACKn,
    input  logic [31:0] busDataIn
);

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  siz_q, siz_d;
    logic        rwn_q, rwn_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cbreq_q, cbreq_d;
    logic [1:0]  beat_q, beat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_last_q, rsp_last_d;
    logic [31:0] rdata_q, rdata_d;

    logic ack, timeout, strobe, waiting, err_st;

    assign ack     = ~ramACKn;
    assign waiting = (state_q == ST_WAIT) || (state_q == ST_BURST);
    assign err_st  = (state_q == ST_ERR);
    // The address strobe stays asserted through ERR; TERM is where it negates.
    assign strobe  = (state_q == ST_ADDR) || waiting || err_st;

`ifdef BUS_TIMEOUT_EN
    logic wd_clear, wd_run, wd_expired;

    assign wd_clear = (state_q == ST_IDLE) || (waiting && ack);
    assign wd_run   = (state_q == ST_ADDR) || waiting;

    bus_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (sysClk),
        .rst    (sysRESET),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(wd_expired)
    );

    assign timeout = wd_expired && waiting && !ack;
    assign rspErr  = err_st;
`else
    assign timeout = 1'b0;
    assign rspErr  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        siz_d       = siz_q;
        rwn_d       = rwn_q;
        wdata_d     = wdata_q;
        cbreq_d     = cbreq_q;
        beat_d      = beat_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    state_d = ST_ADDR;
                    addr_d  = reqAddr;
                    siz_d   = reqSIZ;
                    rwn_d   = reqRWn;
                    wdata_d = reqWData;
                    cbreq_d = burst_ok(reqBurst, reqRWn, reqSIZ, reqAddr);
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: begin
                if (ack) begin
                    rsp_valid_d = 1'b1;
                    if (rwn_q) rdata_d = busDataIn;
                    if (cbreq_q && !cpuCBACKn) begin
                        state_d = ST_BURST;
                        beat_d  = 2'd1;
                    end else begin
                        rsp_last_d = 1'b1;
                        cbreq_d    = 1'b0;
                        state_d    = ST_TERM;
                    end
                end else if (timeout) begin
                    cbreq_d = 1'b0;
                    state_d = ST_ERR;
                end
            end
            ST_BURST: begin
                if (ack) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = busDataIn;
                    if (beat_q == 2'(BURST_BEATS - 1)) begin
                        rsp_last_d = 1'b1;
                        beat_d     = 2'd0;
                        state_d    = ST_TERM;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        // Drop the burst request once only the final beat is outstanding.
                        if (beat_q == 2'd2) cbreq_d = 1'b0;
                    end
                end else if (timeout) begin
                    cbreq_d = 1'b0;
                    beat_d  = 2'd0;
                    state_d = ST_ERR;
                end
            end
            ST_ERR: state_d = ST_TERM;
            ST_TERM: begin
                cbreq_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (sysRESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            siz_q       <= '0;
            rwn_q       <= 1'b1;
            wdata_q     <= '0;
            cbreq_q     <= 1'b0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            siz_q       <= siz_d;
            rwn_q       <= rwn_d;
            wdata_q     <= wdata_d;
            cbreq_q     <= cbreq_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rdata_q     <= rdata_d;
        end
    end

    assign reqReady   = (state_q == ST_IDLE);
    assign cpuAddr    = addr_q;
    assign cpuSIZ     = siz_q;
    assign cpuRWn     = strobe ? rwn_q : 1'b1;
    assign cpuASn     = ~strobe;
    assign cpuCBREQn  = ~(cbreq_q && ((state_q == ST_ADDR) || waiting));
    assign busDataOut = wdata_q;
    assign busDataOE  = strobe && !rwn_q;
    assign rspValid   = rsp_valid_q || err_st;
    assign rspLast    = rsp_last_q || err_st;
    assign rspRData   = rdata_q;

endmodule
